matrix_result_streamer: RTL
===========================

Name: matrix_result_streamer

Overview:
Sequential back end for the combinational matrix multiplier. It captures the full result matrix and its per-element 5-bit exception flags in one load handshake. It then streams the elements out one per cycle in row-major order over a valid/ready interface. It also holds a sticky OR of all exception flags, so downstream logic (writeback, activation, host interface) can read products serially.

Parameters:
DATA_WIDTH, 32, element width (FP32 bit pattern, passed through untouched)
MATRIX_A_ROWS, 4, result rows (>=1)
MATRIX_B_COLS, 4, result columns (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
matrix_in  input  DATA_WIDTH x [MATRIX_A_ROWS][MATRIX_B_COLS]  result matrix from multiplier
exceptions_in  input  5 x [MATRIX_A_ROWS][MATRIX_B_COLS]  per-element exception flags
load_valid  input  1  matrix_in/exceptions_in valid
load_ready  output  1  block can accept a matrix (high only in IDLE)
out_valid  output  1  out_* fields hold a valid element
out_ready  input  1  downstream accepts element
out_data  output  DATA_WIDTH  current element
out_exc  output  5  exception flags of current element
out_row  output  max(1,$clog2(MATRIX_A_ROWS))  row index of current element
out_col  output  max(1,$clog2(MATRIX_B_COLS))  column index of current element
out_last  output  1  current element is [ROWS-1][COLS-1]
done  output  1  one-cycle pulse after last element accepted
exc_summary  output  5  OR of all captured exception flags, held until next load

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, load_ready=1, out_valid=0, out_data=0, out_exc=0, out_row=0, out_col=0, out_last=0, done=0, exc_summary=0. Captured storage does not need reset.
- States: IDLE, STREAM.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid&&load_ready: register all elements and flags, and set exc_summary = OR over all exceptions_in.
  - Set row=col=0 and go to STREAM.
  - out_valid rises the next cycle with element [0][0] (load-to-first-element latency 1).
- STREAM:
  - load_ready=0; load_valid is ignored and the captured data is unaffected by later changes on matrix_in.
  - out_valid=1 while in STREAM.
  - While out_valid&&!out_ready, all out_* fields stay stable (no skip, no advance).
  - On out_valid&&out_ready:
    - col<COLS-1: col+1.
    - col==COLS-1 and row<ROWS-1: col=0, row+1.
    - At [ROWS-1][COLS-1]: go to IDLE and pulse done for one cycle.
- Timing after the last handshake: in the cycle after it, done=1, out_valid=0, load_ready=1. A new load is accepted in that cycle at the earliest (one-bubble gap between matrices).
- out_last = (row==ROWS-1)&&(col==COLS-1) while out_valid; 0 otherwise.
- Throughput: one element per cycle with out_ready held high; ROWS*COLS cycles per matrix, plus 1 load cycle.
- 1x1 configuration: the only element has out_last=1 on the first valid cycle.
- exc_summary: updated only on load accept, otherwise held, including through IDLE.
- Reset mid-stream: immediately returns to reset values, and the partial matrix is discarded. No done pulse is emitted.
- Elements are pure pass-through: no arithmetic, no rounding, bit-exact.

Decomposition:
- Shared package matmul_pkg:
  - localparam EXC_W=5, plus exception bit-position constants matching fpu_lib (invalid, divzero, overflow, underflow, inexact).
  - typedef enum {IDLE, STREAM} stream_state_t.
- One sub-module, mat_index_counter: row/col counter with advance input and wrap/last outputs, parameterised by ROWS/COLS. It is reusable by a future matrix loader.

Test Plan:
- Reset, then load a 4x4 with element [i][j] = 32'h3F800000 + (i*4+j) and all exceptions 0, with out_ready=1 -> 16 consecutive valid cycles in row-major order; out_last only on [3][3]; done pulses the cycle after; exc_summary=0.
- Same load with out_ready toggled 1,0,0,1,... -> out_data/out_row/out_col held during stalls; no element lost or duplicated; 16 total handshakes.
- exceptions_in[1][2]=5'b00100 and [3][0]=5'b00001 -> out_exc nonzero only on those elements; exc_summary=5'b00101 from the cycle after load.
- load_valid held high and matrix_in changed every cycle during STREAM -> load_ready=0 throughout; streamed values equal the originally captured matrix; the next load is accepted in the done cycle.
- Assert rst mid-stream at element [2][1] -> out_valid=0 and load_ready=1 asynchronously; no done pulse; a fresh load then streams from [0][0].
- MATRIX_A_ROWS=1, MATRIX_B_COLS=1, element 32'hC0400000 -> a single valid cycle with out_last=1, out_row=0, out_col=0, then done.

Source files
------------

// File: rtl/matmul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmul_pkg : shared exception-flag layout and streamer state type        |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package matmul_pkg;

  localparam int EXC_W         = 5;
  // Bit positions follow the fpu_lib flag vector (NV DZ OF UF NX).
  localparam int EXC_INVALID   = 4;
  localparam int EXC_DIVZERO   = 3;
  localparam int EXC_OVERFLOW  = 2;
  localparam int EXC_UNDERFLOW = 1;
  localparam int EXC_INEXACT   = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/mat_index_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mat_index_counter : row-major row/col walker with last and wrap flags    |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module mat_index_counter
  import matmul_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last,
  output logic             wrap
);

  logic w_col_end;
  logic w_row_end;

  assign w_col_end = (col == COL_W'(COLS - 1));
  assign w_row_end = (row == ROW_W'(ROWS - 1));
  assign last      = w_col_end && w_row_end;
  assign wrap      = advance && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (w_col_end) begin
        col <= '0;
        row <= w_row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_result_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_result_streamer : captures a result matrix and streams it out     |
// | row-major over valid/ready with a sticky exception summary. Rev 1.0      |
// +--------------------------------------------------------------------------+
module matrix_result_streamer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MATRIX_A_ROWS = 4,
  parameter int MATRIX_B_COLS = 4,
  localparam int ROW_W = (MATRIX_A_ROWS > 1) ? $clog2(MATRIX_A_ROWS) : 1,
  localparam int COL_W = (MATRIX_B_COLS > 1) ? $clog2(MATRIX_B_COLS) : 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [MATRIX_A_ROWS-1:0][MATRIX_B_COLS-1:0][DATA_WIDTH-1:0] matrix_in,
  input  logic [MATRIX_A_ROWS-1:0][MATRIX_B_COLS-1:0][EXC_W-1:0]      exceptions_in,
  input  logic                                                  load_valid,
  output logic                                                  load_ready,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [DATA_WIDTH-1:0]                                 out_data,
  output logic [EXC_W-1:0]                                      out_exc,
  output logic [ROW_W-1:0]                                      out_row,
  output logic [COL_W-1:0]                                      out_col,
  output logic                                                  out_last,
  output logic                                                  done,
  output logic [EXC_W-1:0]                                      exc_summary
);

  stream_state_t r_state;
  stream_state_t w_next_state;

  logic [MATRIX_A_ROWS-1:0][MATRIX_B_COLS-1:0][DATA_WIDTH-1:0] r_mat;
  logic [MATRIX_A_ROWS-1:0][MATRIX_B_COLS-1:0][EXC_W-1:0]      r_exc;
  logic [EXC_W-1:0] r_exc_summary;
  logic [EXC_W-1:0] w_exc_or;
  logic             r_done;
  logic             w_load_acc;
  logic             w_out_hs;
  logic             w_last;
  logic             w_wrap;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;

  assign w_load_acc = load_valid && load_ready;
  assign w_out_hs   = out_valid && out_ready;

  mat_index_counter #(
    .ROWS (MATRIX_A_ROWS),
    .COLS (MATRIX_B_COLS)
  ) u_index (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_load_acc),
    .advance (w_out_hs),
    .row     (w_row),
    .col     (w_col),
    .last    (w_last),
    .wrap    (w_wrap)
  );

  always_comb begin
    w_exc_or = '0;
    for (int r = 0; r < MATRIX_A_ROWS; r++) begin
      for (int c = 0; c < MATRIX_B_COLS; c++) begin
        w_exc_or = w_exc_or | exceptions_in[r][c];
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    load_ready   = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) w_next_state = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (w_wrap) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_done        <= 1'b0;
      r_exc_summary <= '0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_wrap;
      if (w_load_acc) r_exc_summary <= w_exc_or;
    end
  end

  // Payload storage carries no reset; it is only observed while out_valid.
  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_mat <= matrix_in;
      r_exc <= exceptions_in;
    end
  end

  assign out_data    = out_valid ? r_mat[w_row][w_col] : '0;
  assign out_exc     = out_valid ? r_exc[w_row][w_col] : '0;
  assign out_row     = w_row;
  assign out_col     = w_col;
  assign out_last    = out_valid && w_last;
  assign done        = r_done;
  assign exc_summary = r_exc_summary;

endmodule
`default_nettype wire
